// File: rtl/i2c_pkg.sv
// Shared types for the single-byte I2C master.
// State, quarter-phase and R/W encodings.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_NACK,
        STOP
    } state_e;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-phase generator: CLK_DIV clocks per phase, four phases per bit.
// phase_tick marks the last clock of the current phase.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   run,
    output phase_e phase,
    output logic   phase_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign phase_tick = run && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= PH0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= PH0;
        end else if (phase_tick) begin
            cnt   <= '0;
            phase <= phase_e'(phase + 2'd1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, addr+rw, ACK, one data byte, ACK/NACK, STOP.
// SCL is push-pull; SDA is open-drain (pull low or release).
module i2c_master_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    import i2c_pkg::*;

    state_e     state;
    phase_e     phase;
    logic       phase_tick;
    logic       run;
    logic       sda_oe;
    logic       samp;
    logic       rw_q;
    logic [7:0] shreg;
    logic [7:0] data_q;
    logic [2:0] bit_cnt;

    assign run = (state != IDLE);
    assign sda = sda_oe ? 1'b0 : 1'bz;

    i2c_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .phase     (phase),
        .phase_tick(phase_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            data_out <= '0;
            samp     <= 1'b0;
            rw_q     <= 1'b0;
            shreg    <= '0;
            data_q   <= '0;
            bit_cnt  <= 3'd7;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                scl    <= 1'b1;
                sda_oe <= 1'b0;
                if (enable) begin
                    shreg   <= {addr, rw};
                    rw_q    <= rw;
                    data_q  <= data_in;
                    ack_err <= 1'b0;
                    ready   <= 1'b0;
                    state   <= START;
                end
            end else if (phase_tick) begin
                unique case (phase)
                    PH0: ;
                    PH1: begin
                        scl <= 1'b1;
                        if (state == START) sda_oe <= 1'b1;
                    end
                    PH2: begin
                        samp <= sda;
                        if (state == RD_DATA) begin
                            shreg <= {shreg[6:0], sda};
                            if (bit_cnt == 3'd0)
                                data_out <= {shreg[6:0], sda};
                        end
                        if (state == STOP) sda_oe <= 1'b0;
                    end
                    PH3: begin
                        // bit boundary: ph0 of the next bit starts here
                        scl <= (state == STOP);
                        unique case (state)
                            START: begin
                                state   <= ADDR;
                                bit_cnt <= 3'd7;
                                sda_oe  <= ~shreg[7];
                            end
                            ADDR, WR_DATA: begin
                                if (bit_cnt != 3'd0) begin
                                    bit_cnt <= bit_cnt - 3'd1;
                                    shreg   <= {shreg[6:0], 1'b0};
                                    sda_oe  <= ~shreg[6];
                                end else begin
                                    state  <= (state == ADDR) ? ADDR_ACK : WR_ACK;
                                    sda_oe <= 1'b0;
                                end
                            end
                            ADDR_ACK: begin
                                if (samp) begin
                                    ack_err <= 1'b1;
                                    state   <= STOP;
                                    sda_oe  <= 1'b1;
                                end else if (rw_q == RW_WRITE) begin
                                    state   <= WR_DATA;
                                    bit_cnt <= 3'd7;
                                    shreg   <= data_q;
                                    sda_oe  <= ~data_q[7];
                                end else begin
                                    state   <= RD_DATA;
                                    bit_cnt <= 3'd7;
                                    sda_oe  <= 1'b0;
                                end
                            end
                            WR_ACK: begin
                                if (samp) ack_err <= 1'b1;
                                state  <= STOP;
                                sda_oe <= 1'b1;
                            end
                            RD_DATA: begin
                                sda_oe <= 1'b0;
                                if (bit_cnt != 3'd0)
                                    bit_cnt <= bit_cnt - 3'd1;
                                else
                                    state <= RD_NACK;
                            end
                            RD_NACK: begin
                                state  <= STOP;
                                sda_oe <= 1'b1;
                            end
                            STOP: begin
                                state <= IDLE;
                                done  <= 1'b1;
                                ready <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule
